// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational RV32 ALU between two requesters.
// Registers ALU operands on issue, captures the result one cycle later, returns it tagged.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_control,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [TAG_W-1:0] req0_tag,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_control,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [TAG_W-1:0] req1_tag,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic [TAG_W-1:0] rsp0_tag,
  output logic             rsp0_err,

  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic [TAG_W-1:0] rsp1_tag,
  output logic             rsp1_err,

  output logic [3:0]       alu_control,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  input  logic [WIDTH-1:0] alu_result,

  output logic [31:0]      issue_cnt
);

  typedef enum logic {REQ0 = 1'b0, REQ1 = 1'b1} req_id_e;

  function automatic logic op_illegal(input logic [3:0] c);
    case (c)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0110, 4'b0111,
      4'b1000, 4'b1010, 4'b1011, 4'b1100, 4'b1110: op_illegal = 1'b0;
      default:                                     op_illegal = 1'b1;
    endcase
  endfunction

  logic             inflight_q, inflight_d;
  req_id_e          owner_q, owner_d;
  req_id_e          last_grant_q, last_grant_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             illegal_q, illegal_d;
  logic [3:0]       alu_control_q, alu_control_d;
  logic [WIDTH-1:0] alu_in1_q, alu_in1_d;
  logic [WIDTH-1:0] alu_in2_q, alu_in2_d;
  logic [31:0]      issue_cnt_q, issue_cnt_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q [2];
  logic [WIDTH-1:0] rsp_data_d [2];
  logic [TAG_W-1:0] rsp_tag_q [2];
  logic [TAG_W-1:0] rsp_tag_d [2];
  logic [1:0]       rsp_err_q, rsp_err_d;

  logic [1:0] req_valid, rsp_ready, elig, cand, grant, cap;
  req_id_e    winner;
  logic       fire;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // Arbitration: a requester with an op in flight or an undrained response sits out.
  always_comb begin
    elig[0] = ~(inflight_q & (owner_q == REQ0)) & (~rsp_valid_q[0] | rsp_ready[0]);
    elig[1] = ~(inflight_q & (owner_q == REQ1)) & (~rsp_valid_q[1] | rsp_ready[1]);
    cand    = req_valid & elig;
    if (cand == 2'b11) begin
      winner = (last_grant_q == REQ0) ? REQ1 : REQ0;
    end else if (cand[1]) begin
      winner = REQ1;
    end else begin
      winner = REQ0;
    end
    grant[0] = cand[0] & (winner == REQ0);
    grant[1] = cand[1] & (winner == REQ1);
    fire     = |grant;
    cap[0]   = inflight_q & (owner_q == REQ0);
    cap[1]   = inflight_q & (owner_q == REQ1);
  end

  always_comb begin
    alu_control_d = alu_control_q;
    alu_in1_d     = alu_in1_q;
    alu_in2_d     = alu_in2_q;
    tag_d         = tag_q;
    illegal_d     = illegal_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    inflight_d    = fire;
    issue_cnt_d   = issue_cnt_q + 32'(fire);

    if (fire) begin
      if (winner == REQ1) begin
        alu_control_d = req1_control;
        alu_in1_d     = req1_a;
        alu_in2_d     = req1_b;
        tag_d         = req1_tag;
        illegal_d     = op_illegal(req1_control);
      end else begin
        alu_control_d = req0_control;
        alu_in1_d     = req0_a;
        alu_in2_d     = req0_b;
        tag_d         = req0_tag;
        illegal_d     = op_illegal(req0_control);
      end
      owner_d      = winner;
      last_grant_d = winner;
    end

    // A capture landing on the draining edge keeps valid high with the new result.
    rsp_valid_d = rsp_valid_q & ~rsp_ready;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_err_d   = rsp_err_q;
    for (int unsigned i = 0; i < 2; i++) begin
      if (cap[i]) begin
        rsp_valid_d[i] = 1'b1;
        rsp_data_d[i]  = illegal_q ? '0 : alu_result;
        rsp_tag_d[i]   = tag_q;
        rsp_err_d[i]   = illegal_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q    <= 1'b0;
      owner_q       <= REQ0;
      last_grant_q  <= REQ1;
      tag_q         <= '0;
      illegal_q     <= 1'b0;
      alu_control_q <= '0;
      alu_in1_q     <= '0;
      alu_in2_q     <= '0;
      issue_cnt_q   <= '0;
      rsp_valid_q   <= '0;
      rsp_err_q     <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        rsp_data_q[i] <= '0;
        rsp_tag_q[i]  <= '0;
      end
    end else begin
      inflight_q    <= inflight_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      tag_q         <= tag_d;
      illegal_q     <= illegal_d;
      alu_control_q <= alu_control_d;
      alu_in1_q     <= alu_in1_d;
      alu_in2_q     <= alu_in2_d;
      issue_cnt_q   <= issue_cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_data_q    <= rsp_data_d;
      rsp_tag_q     <= rsp_tag_d;
    end
  end

  assign req0_ready  = grant[0];
  assign req1_ready  = grant[1];
  assign rsp0_valid  = rsp_valid_q[0];
  assign rsp0_data   = rsp_data_q[0];
  assign rsp0_tag    = rsp_tag_q[0];
  assign rsp0_err    = rsp_err_q[0];
  assign rsp1_valid  = rsp_valid_q[1];
  assign rsp1_data   = rsp_data_q[1];
  assign rsp1_tag    = rsp_tag_q[1];
  assign rsp1_err    = rsp_err_q[1];
  assign alu_control = alu_control_q;
  assign alu_in1     = alu_in1_q;
  assign alu_in2     = alu_in2_q;
  assign issue_cnt   = issue_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, vector table, response scoreboard per requester,
// and directed sequences for round-robin, backpressure, reset and counter wrap.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_control, req1_control;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_tag, req1_tag;
  logic        rsp0_valid, rsp0_ready, rsp0_err, rsp1_valid, rsp1_ready, rsp1_err;
  logic [31:0] rsp0_data, rsp1_data;
  logic [3:0]  rsp0_tag, rsp1_tag;
  logic [3:0]  alu_control;
  logic [31:0] alu_in1, alu_in2, alu_result, issue_cnt;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_control(req0_control),
    .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_control(req1_control),
    .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp0_tag(rsp0_tag), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .rsp1_tag(rsp1_tag), .rsp1_err(rsp1_err),
    .alu_control(alu_control), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_result(alu_result), .issue_cnt(issue_cnt)
  );

  // External ALU; illegal codes return garbage so result zeroing is visible.
  always_comb begin
    case (alu_control)
      4'b0000: alu_result = alu_in1 + alu_in2;
      4'b0001: alu_result = alu_in1 - alu_in2;
      4'b0010: alu_result = alu_in1 & alu_in2;
      4'b0100: alu_result = alu_in1 | alu_in2;
      4'b0110: alu_result = alu_in1 ^ alu_in2;
      4'b0111: alu_result = {31'b0, alu_in1 == alu_in2};
      4'b1000: alu_result = alu_in1 << alu_in2[4:0];
      4'b1010: alu_result = alu_in1 >> alu_in2[4:0];
      4'b1011: alu_result = $signed(alu_in1) >>> alu_in2[4:0];
      4'b1100: alu_result = {31'b0, $signed(alu_in1) < $signed(alu_in2)};
      4'b1110: alu_result = {31'b0, alu_in1 < alu_in2};
      default: alu_result = 32'hDEADBEEF;
    endcase
  end

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        err;
  } exp_t;

  typedef struct {
    int          r;
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  t;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  exp_t        sb0[$], sb1[$];
  logic [31:0] exp_d0, exp_d1;
  logic        exp_e0, exp_e1;
  int          hs0 = 0, hs1 = 0;
  int          n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: push on request handshake, pop on response handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      chk("one_ready", {31'b0, req0_ready & req1_ready}, 32'd0);
      if (req0_valid && req0_ready) begin
        sb0.push_back('{data: exp_d0, tag: req0_tag, err: exp_e0});
        hs0++;
      end
      if (req1_valid && req1_ready) begin
        sb1.push_back('{data: exp_d1, tag: req1_tag, err: exp_e1});
        hs1++;
      end
      if (rsp0_valid && rsp0_ready) begin
        if (sb0.size() == 0) chk("rsp0_unexpected", 32'(sb0.size()), 32'd1);
        else begin
          e = sb0.pop_front();
          chk("rsp0_data", rsp0_data, e.data);
          chk("rsp0_tag", {28'b0, rsp0_tag}, {28'b0, e.tag});
          chk("rsp0_err", {31'b0, rsp0_err}, {31'b0, e.err});
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        if (sb1.size() == 0) chk("rsp1_unexpected", 32'(sb1.size()), 32'd1);
        else begin
          e = sb1.pop_front();
          chk("rsp1_data", rsp1_data, e.data);
          chk("rsp1_tag", {28'b0, rsp1_tag}, {28'b0, e.tag});
          chk("rsp1_err", {31'b0, rsp1_err}, {31'b0, e.err});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_control = '0; req0_a = '0; req0_b = '0; req0_tag = '0;
    req1_valid = 0; req1_control = '0; req1_a = '0; req1_b = '0; req1_tag = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    sb0.delete();
    sb1.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic set_req(input int r, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] t, input logic [31:0] ed, input logic ee);
    if (r == 0) begin
      req0_control = c; req0_a = a; req0_b = b; req0_tag = t; exp_d0 = ed; exp_e0 = ee; req0_valid = 1;
    end else begin
      req1_control = c; req1_a = a; req1_b = b; req1_tag = t; exp_d1 = ed; exp_e1 = ee; req1_valid = 1;
    end
  endtask

  task automatic issue(input vec_t v);
    bit ok;
    ok = 0;
    set_req(v.r, v.c, v.a, v.b, v.t, v.ed, v.ee);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((v.r == 0) ? req0_ready : req1_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("issue_timeout", 32'(ok), 32'd1);
    step();
    if (v.r == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  vec_t vecs[16];
  logic [31:0] h1;
  int win;

  initial begin
    rst_n = 1'b0;
    rsp0_ready = 1; rsp1_ready = 1;
    exp_d0 = '0; exp_d1 = '0; exp_e0 = 0; exp_e1 = 0;
    idle_inputs();
    vecs[0]  = '{0, 4'b0000, 32'd5,        32'd7,        4'h1, 32'd12,         1'b0};
    vecs[1]  = '{1, 4'b0001, 32'd10,       32'd3,        4'h2, 32'd7,          1'b0};
    vecs[2]  = '{0, 4'b0010, 32'hF0F0F0F0, 32'h0FF00FF0, 4'h3, 32'h00F000F0,   1'b0};
    vecs[3]  = '{1, 4'b0100, 32'h12340000, 32'h00005678, 4'h4, 32'h12345678,   1'b0};
    vecs[4]  = '{0, 4'b0110, 32'hFFFF0000, 32'h0F0F0F0F, 4'h5, 32'hF0F00F0F,   1'b0};
    vecs[5]  = '{1, 4'b0011, 32'd1,        32'd1,        4'h6, 32'd0,          1'b1};
    vecs[6]  = '{1, 4'b0111, 32'd9,        32'd9,        4'h7, 32'd1,          1'b0};
    vecs[7]  = '{0, 4'b1000, 32'd1,        32'd31,       4'h8, 32'h80000000,   1'b0};
    vecs[8]  = '{0, 4'b1010, 32'h80000000, 32'd4,        4'h9, 32'h08000000,   1'b0};
    vecs[9]  = '{1, 4'b1011, 32'h80000000, 32'd4,        4'hA, 32'hF8000000,   1'b0};
    vecs[10] = '{0, 4'b1100, 32'hFFFFFFFF, 32'd1,        4'hB, 32'd1,          1'b0};
    vecs[11] = '{1, 4'b1110, 32'hFFFFFFFF, 32'd1,        4'hC, 32'd0,          1'b0};
    vecs[12] = '{0, 4'b1111, 32'd3,        32'd4,        4'hD, 32'd0,          1'b1};
    vecs[13] = '{0, 4'b0101, 32'd3,        32'd4,        4'hE, 32'd0,          1'b1};
    vecs[14] = '{1, 4'b1001, 32'd3,        32'd4,        4'hF, 32'd0,          1'b1};
    vecs[15] = '{1, 4'b1101, 32'd3,        32'd4,        4'h0, 32'd0,          1'b1};

    // Reset values, checked while reset is still asserted.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
    chk("rst_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
    chk("rst_rsp0_data", rsp0_data, 32'd0);
    chk("rst_rsp1_tag", {28'b0, rsp1_tag}, 32'd0);
    chk("rst_alu_control", {28'b0, alu_control}, 32'd0);
    chk("rst_alu_in1", alu_in1, 32'd0);
    chk("rst_issue_cnt", issue_cnt, 32'd0);
    do_reset();

    // Single op, latency and ready in the request cycle.
    set_req(0, 4'b0000, 32'd5, 32'd7, 4'd3, 32'd12, 1'b0);
    #1 chk("single_req0_ready", {31'b0, req0_ready}, 32'd1);
    step();
    req0_valid = 0;
    chk("single_inflight_no_rsp", {31'b0, rsp0_valid}, 32'd0);
    chk("single_issue_cnt", issue_cnt, 32'd1);
    step();
    chk("single_rsp_valid", {31'b0, rsp0_valid}, 32'd1);
    chk("single_rsp_data", rsp0_data, 32'd12);
    chk("single_rsp_tag", {28'b0, rsp0_tag}, 32'd3);
    chk("single_rsp_err", {31'b0, rsp0_err}, 32'd0);
    step();
    chk("single_drained", {31'b0, rsp0_valid}, 32'd0);

    // Table-driven vectors, all responses checked by the scoreboard.
    foreach (vecs[i]) issue(vecs[i]);
    repeat (4) step();

    // Tie and round-robin from reset.
    do_reset();
    set_req(0, 4'b0001, 32'd10, 32'd3, 4'd1, 32'd7, 1'b0);
    set_req(1, 4'b1011, 32'h80000000, 32'd4, 4'd2, 32'hF8000000, 1'b0);
    for (int k = 0; k < 8; k++) begin
      #1;
      win = req1_ready ? 1 : (req0_ready ? 0 : -1);
      chk("rr_grant", 32'(win), 32'(k % 2));
      step();
      chk("rr_alu_control", {28'b0, alu_control}, (k % 2 == 0) ? 32'b0001 : 32'b1011);
    end
    req0_valid = 0; req1_valid = 0;
    repeat (4) step();

    // Backpressure on rsp0 while req1 keeps issuing.
    rsp0_ready = 0;
    set_req(0, 4'b0000, 32'd100, 32'd23, 4'd5, 32'd123, 1'b0);
    set_req(1, 4'b0000, 32'd1, 32'd2, 4'd6, 32'd3, 1'b0);
    begin
      bit ok;
      ok = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (req0_ready) begin ok = 1; break; end
      end
      if (!ok) chk("bp_issue_timeout", 32'(ok), 32'd1);
    end
    step();
    step();
    chk("bp_rsp_valid", {31'b0, rsp0_valid}, 32'd1);
    h1 = 32'(hs1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_req0_blocked", {31'b0, req0_ready}, 32'd0);
      chk("bp_rsp_hold_valid", {31'b0, rsp0_valid}, 32'd1);
      chk("bp_rsp_hold_data", rsp0_data, 32'd123);
      chk("bp_rsp_hold_tag", {28'b0, rsp0_tag}, 32'd5);
      step();
    end
    chk("bp_req1_progress", {31'b0, (32'(hs1) - h1) >= 2}, 32'd1);
    rsp0_ready = 1;
    #1 chk("bp_req0_ready_on_drain", {31'b0, req0_ready}, 32'd1);
    step();
    req0_valid = 0; req1_valid = 0;
    repeat (4) step();

    // Reset while an op is in flight.
    do_reset();
    set_req(0, 4'b0000, 32'd2, 32'd3, 4'd7, 32'd5, 1'b0);
    @(negedge clk);
    chk("mid_req0_ready", {31'b0, req0_ready}, 32'd1);
    step();
    req0_valid = 0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
    chk("mid_rst_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
    chk("mid_rst_issue_cnt", issue_cnt, 32'd0);
    sb0.delete();
    sb1.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mid_no_stale_rsp", {31'b0, rsp0_valid}, 32'd0);
    end
    set_req(0, 4'b0000, 32'd4, 32'd4, 4'd8, 32'd8, 1'b0);
    set_req(1, 4'b0000, 32'd6, 32'd6, 4'd9, 32'd12, 1'b0);
    #1;
    chk("mid_tie_req0", {31'b0, req0_ready}, 32'd1);
    chk("mid_tie_req1", {31'b0, req1_ready}, 32'd0);
    step();
    req0_valid = 0; req1_valid = 0;
    repeat (4) step();

    // Counter wrap.
    force dut.issue_cnt_q = 32'hFFFFFFFF;
    #1 release dut.issue_cnt_q;
    #1 chk("wrap_preload", issue_cnt, 32'hFFFFFFFF);
    issue('{0, 4'b0000, 32'd1, 32'd1, 4'd1, 32'd2, 1'b0});
    chk("wrap_to_zero", issue_cnt, 32'd0);
    repeat (5) step();

    chk("sb0_empty", 32'(sb0.size()), 32'd0);
    chk("sb1_empty", 32'(sb1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 32-bit RV32 ALU (4-bit op code, two operands, one result) between two requesters, e.g. the core issue stage and a co-processor port.
- Round-robin arbitration on a valid/ready request channel per requester.
- Drives the ALU operand/control registers, captures the ALU result one cycle later and returns it on a per-requester valid/ready response channel with an echoed tag.
- Flags illegal op codes and keeps a wrapping issue counter.

Parameters:
- WIDTH, 32, operand/result width
- TAG_W, 4, request tag width, echoed unchanged on the response

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- reqN_valid  input  1  request valid, N=0,1
- reqN_ready  output  1  request accepted this cycle when valid&ready
- reqN_control  input  4  ALU op code
- reqN_a  input  WIDTH  operand 1
- reqN_b  input  WIDTH  operand 2
- reqN_tag  input  TAG_W  request tag
- rspN_valid  output  1  response valid
- rspN_ready  input  1  response consumed when valid&ready
- rspN_data  output  WIDTH  result
- rspN_tag  output  TAG_W  tag of the originating request
- rspN_err  output  1  op code was illegal
- alu_control  output  4  to ALU control, registered
- alu_in1  output  WIDTH  to ALU operand 1, registered
- alu_in2  output  WIDTH  to ALU operand 2, registered
- alu_result  input  WIDTH  from ALU output
- issue_cnt  output  32  total accepted requests, wraps at 2^32

Behaviour:
- Reset (async, rst_n=0):
  - rspN_valid=0, rspN_data=0, rspN_tag=0, rspN_err=0.
  - alu_control=0000, alu_in1=0, alu_in2=0, issue_cnt=0.
  - inflight=0; last_grant=1, so requester 0 wins the first tie.
  - Reset mid-operation drops any in-flight op; no response is produced for it.
- Eligibility:
  - eligibleN = ~(inflight & owner==N) & (~rspN_valid | rspN_ready).
  - A requester never has more than one op in flight or pending, so per-requester throughput is 1 op per 2 cycles. With both requesters alternating, ALU utilisation reaches 1 op/cycle.
- Grant:
  - Candidates: reqN_valid & eligibleN.
  - One candidate: that one wins. Two candidates: the one != last_grant wins.
  - reqN_ready = candidateN & winner==N. Combinational from state, rspN_ready and both req_valid; it never depends on the port's own data fields.
  - At most one reqN_ready high per cycle.
- Issue edge (a handshake occurs):
  - alu_control/alu_in1/alu_in2 load the winner's fields.
  - Winner's tag and an illegal flag are stored. Legal codes are 0000, 0001, 0010, 0100, 0110, 0111, 1000, 1010, 1011, 1100, 1110; any other code is illegal.
  - inflight=1, owner=winner, last_grant=winner, issue_cnt++.
- No handshake: alu_* registers hold their value; inflight=0.
- Capture edge (inflight=1):
  - rsp[owner]_data = illegal ? 0 : alu_result.
  - rsp[owner]_err = illegal; rsp[owner]_tag = stored tag; rsp[owner]_valid=1.
  - Issue and capture can share an edge; the new issue overwrites the alu_* registers after the old result is sampled.
- Latency: request handshake at edge E means rspN_valid is high after edge E+1 (2 cycles).
- Response hold:
  - rspN_valid, data, tag and err stay stable until rspN_ready=1.
  - On the draining edge valid clears, unless a capture for N lands on the same edge, in which case valid stays 1 with the new data.
- Results are never reordered within a requester. There is no ordering guarantee between requesters.
- No combinational path from alu_result to any output.

Test Plan:
- Single op: req0 {control=0000, a=5, b=7, tag=3}, rsp0_ready=1 -> reqN_ready=1 that cycle; rsp0_valid 2 cycles later, data=12, tag=3, err=0; issue_cnt=1.
- Tie and round-robin: both valid every cycle, rsp ready=1, req0 sub 10-3, req1 sra 0x80000000>>>4 -> grants alternate 0,1,0,1 starting with 0. rsp0_data=7, rsp1_data=0xF8000000. alu_control changes every cycle.
- Backpressure: req0 completes with rsp0_ready=0 for 5 cycles, req0_valid held -> req0_ready=0 throughout and rsp0 stays stable. On the cycle rsp0_ready=1, req0_ready=1 in the same cycle. req1 keeps issuing meanwhile.
- Illegal op: req1 control=0011, a=1, b=1 -> rsp1_err=1, rsp1_data=0. The next legal req1 (0111, 9, 9) gives err=0, data=1.
- Reset mid-flight: assert rst_n=0 one cycle after a req0 handshake -> all rsp_valid=0 and issue_cnt=0 immediately (asynchronous); no stale response after release; requester 0 wins the next tie.
- Counter wrap: preload via 2^32 issues, or force issue_cnt=0xFFFFFFFF -> next accept gives issue_cnt=0.
